// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared types and helpers for the MEM-stage load/store unit.
//   - mem_size_t  : access size encoding (byte/half/word/dword)
//   - lsu_state_t : controller FSM states
//   - be_mask     : byte-enable mask for a size, shifted to a byte offset
//   - is_misaligned : natural-alignment check for a request
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // 8-bit wide so it covers both 32- and 64-bit data paths; callers
    // truncate to their own byte-enable width.
    function automatic logic [7:0] be_mask(input mem_size_t size,
                                           input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    // has_dword is 0 on a 32-bit data path, where a dword access can never
    // be satisfied by a single word transaction.
    function automatic logic is_misaligned(input mem_size_t size,
                                           input logic [2:0] addr_lo,
                                           input logic has_dword);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return ~has_dword | (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic shared by the load and store paths.
//   Ports:
//     size, offset  : access size and byte offset within the word
//     uns           : zero-extend (1) or sign-extend (0) load data
//     wdata         : LSB-justified store data
//     rdata         : raw memory read word
//     be            : byte enables for the access
//     wdata_sh      : store data moved to its byte lanes
//     rdata_ext     : load data extracted from its lanes and extended
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int OFS_W  = $clog2(DATA_W / 8),
    localparam int IDX_W  = $clog2(DATA_W)
) (
    input  mem_size_t           size,
    input  logic                uns,
    input  logic [OFS_W-1:0]    offset,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic [BE_W-1:0]     be,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic [DATA_W-1:0]   rdata_ext
);

    logic [DATA_W-1:0] rsh;
    logic [IDX_W-1:0]  top;   // index of the loaded value's sign bit
    logic              sgn;

    always_comb begin
        be       = BE_W'(be_mask(size, 3'(offset)));
        wdata_sh = wdata << {offset, 3'b000};
        rsh      = rdata >> {offset, 3'b000};

        case (size)
            SZ_B:    top = IDX_W'(7);
            SZ_H:    top = IDX_W'(15);
            SZ_W:    top = IDX_W'(31);
            default: top = IDX_W'(DATA_W - 1);
        endcase

        sgn = ~uns & rsh[top];
        for (int i = 0; i < DATA_W; i++)
            rdata_ext[i] = (i <= int'(top)) ? rsh[i] : sgn;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   MEM-stage load/store unit: turns a byte-addressed request into a
//   word-oriented DRAM req/ack transaction with byte enables, stalls the
//   pipeline while it is outstanding, and returns aligned, extended loads.
//
//   Build option: LSU_STORE_BUF_EN -- one-entry posted store buffer. A store
//   accepted while idle does not stall; any request arriving while it drains
//   stalls until the drain completes. Without it, stores stall until ack.
//
//   Ports:
//     clk, nrst          : clock, synchronous active-low reset
//     req_*              : MEM-stage request (held until accepted)
//     stall              : freeze pipeline upstream of MEM
//     rsp_valid/rsp_data : one-cycle load-complete pulse / held load result
//     misalign           : one-cycle pulse for a misaligned request
//     acc_err            : one-cycle pulse when the access times out
//     dram_*             : word-addressed memory request/ack interface
// ---------------------------------------------------------------------------
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 12,
    parameter  int TIMEOUT = 255,
    localparam int BE_W    = DATA_W / 8,
    localparam int OFS_W   = $clog2(DATA_W / 8),
    localparam int WA_W    = ADDR_W - OFS_W,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              misalign,
    output logic              acc_err,
    output logic              dram_req,
    output logic              dram_we,
    output logic [WA_W-1:0]   dram_addr,
    output logic [BE_W-1:0]   dram_be,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic              dram_ack,
    input  logic [DATA_W-1:0] dram_rdata
);

`ifdef LSU_STORE_BUF_EN
    localparam logic POST_EN = 1'b1;
`else
    localparam logic POST_EN = 1'b0;
`endif

    lsu_state_t        state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              r_we;
    logic              r_uns;
    logic              r_post;   // current access is a posted store
    mem_size_t         r_size;
    logic [OFS_W-1:0]  r_ofs;

    logic              mis;
    logic              accept;
    logic              tmo_now;
    logic              st_done;

    mem_size_t         al_size;
    logic [OFS_W-1:0]  al_ofs;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;

    assign mis     = is_misaligned(mem_size_t'(req_size), req_addr[2:0], DATA_W == 64);
    assign accept  = nrst && (state == IDLE) && req_valid && !mis;
    assign tmo_now = (state == ACCESS) && !dram_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign st_done = (state == ACCESS) && dram_ack && r_we;

    // One alignment unit serves both directions: while idle it shapes the
    // incoming store, during the access it decodes the returning read word
    // with the captured size/offset.
    assign al_size = (state == IDLE) ? mem_size_t'(req_size) : r_size;
    assign al_ofs  = (state == IDLE) ? req_addr[OFS_W-1:0]   : r_ofs;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .size      (al_size),
        .uns       (r_uns),
        .offset    (al_ofs),
        .wdata     (req_wdata),
        .rdata     (dram_rdata),
        .be        (al_be),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    // Stall is combinational so the accept cycle itself freezes upstream.
    // A store releases the pipe in its ack cycle; a load keeps it through
    // the ack and releases in RESP. A posted store only stalls newcomers.
    assign stall = nrst && (
                     (accept && !(POST_EN && req_we)) ||
                     ((state == ACCESS) && (r_post ? req_valid : !(st_done || tmo_now)))
                   );

    assign misalign = nrst && (state == IDLE) && req_valid && mis;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_post     <= 1'b0;
            r_size     <= SZ_B;
            r_ofs      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            acc_err    <= 1'b0;
            dram_req   <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_be    <= '0;
            dram_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            acc_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ACCESS;
                        tmo_cnt    <= '0;
                        r_we       <= req_we;
                        r_uns      <= req_unsigned;
                        r_post     <= POST_EN && req_we;
                        r_size     <= mem_size_t'(req_size);
                        r_ofs      <= req_addr[OFS_W-1:0];
                        dram_req   <= 1'b1;
                        dram_we    <= req_we;
                        dram_addr  <= req_addr[ADDR_W-1:OFS_W];
                        dram_be    <= al_be;
                        dram_wdata <= al_wdata;
                    end
                end
                ACCESS: begin
                    if (dram_ack) begin
                        dram_req <= 1'b0;
                        dram_we  <= 1'b0;
                        dram_be  <= '0;
                        tmo_cnt  <= '0;
                        r_post   <= 1'b0;
                        if (r_we) begin
                            state <= IDLE;
                        end else begin
                            rsp_data  <= al_rdata;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end else if (tmo_now) begin
                        // Abandon the access; any later ack lands in IDLE
                        // and is ignored there.
                        dram_req <= 1'b0;
                        dram_we  <= 1'b0;
                        dram_be  <= '0;
                        tmo_cnt  <= '0;
                        r_post   <= 1'b0;
                        acc_err  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Directed plus randomized bench for lsu_mem_ctrl (DATA_W=32, ADDR_W=12,
//   TIMEOUT=8). A word-array memory model answers DRAM requests; expected
//   byte enables, lane data and extended loads come from arithmetic on the
//   access size and offset.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    localparam int TMO = 8;
`ifdef LSU_STORE_BUF_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        misalign;
    logic        acc_err;
    logic        dram_req;
    logic        dram_we;
    logic [9:0]  dram_addr;
    logic [3:0]  dram_be;
    logic [31:0] dram_wdata;
    logic        dram_ack;
    logic [31:0] dram_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(12), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .misalign     (misalign),
        .acc_err      (acc_err),
        .dram_req     (dram_req),
        .dram_we      (dram_we),
        .dram_addr    (dram_addr),
        .dram_be      (dram_be),
        .dram_wdata   (dram_wdata),
        .dram_ack     (dram_ack),
        .dram_rdata   (dram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load result from the rules: shift down by the byte offset, keep the
    // access width, sign-extend unless unsigned.
    function automatic logic [31:0] exp_load(input logic [31:0] word, input int ofs,
                                             input int sz, input bit uns);
        logic [63:0] v;
        logic [63:0] m;
        int nbits;
        nbits = 8 * (1 << sz);
        m = (64'd1 << nbits) - 64'd1;
        v = ({32'd0, word} >> (8 * ofs)) & m;
        if (!uns && v[nbits-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // One complete request. lat = ACCESS cycle (1-based) in which ack comes;
    // 0 or > TMO means no ack, so a timeout is expected.
    task automatic xact(input bit we, input int sz, input bit uns, input logic [11:0] addr,
                        input logic [31:0] wd, input int lat);
        int nb, ofs;
        bit mis, tmo, ack;
        logic [9:0]  wa;
        logic [31:0] ebe, ewd, eld;
        nb  = 1 << sz;
        ofs = int'(addr[1:0]);
        wa  = addr[11:2];
        mis = (sz == 3) || ((int'(addr) % nb) != 0);
        ebe = ((32'd1 << nb) - 32'd1) << ofs;
        ewd = wd << (8 * ofs);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = 2'(sz);
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        #1;
        if (mis) begin
            chk("misalign_pulse", 32'(misalign), 32'd1);
            chk("misalign_stall", 32'(stall), 32'd0);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk("misalign_no_req", 32'(dram_req), 32'd0);
            chk("misalign_one_cycle", 32'(misalign), 32'd0);
            return;
        end
        chk("accept_stall", 32'(stall), (POST && we) ? 32'd0 : 32'd1);
        chk("accept_misalign", 32'(misalign), 32'd0);

        tmo = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            ack        = (k == lat);
            dram_ack   = ack;
            dram_rdata = mem[wa];
            #1;
            chk("dram_req", 32'(dram_req), 32'd1);
            chk("dram_addr", 32'(dram_addr), 32'(wa));
            chk("dram_be", 32'(dram_be), ebe);
            chk("dram_we", 32'(dram_we), 32'(we));
            if (we) chk("dram_wdata", dram_wdata, ewd);
            tmo = !ack && (k == TMO);
            chk("access_stall", 32'(stall),
                ((POST && we) || (ack && we) || tmo) ? 32'd0 : 32'd1);
            if (ack || tmo) break;
        end

        eld = exp_load(mem[wa], ofs, sz, uns);
        @(negedge clk);
        dram_ack = 1'b0;
        #1;
        chk("done_req", 32'(dram_req), 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        if (tmo) begin
            chk("acc_err", 32'(acc_err), 32'd1);
            chk("tmo_no_rsp", 32'(rsp_valid), 32'd0);
        end else begin
            chk("no_acc_err", 32'(acc_err), 32'd0);
            if (we) begin
                chk("store_no_rsp", 32'(rsp_valid), 32'd0);
                for (int b = 0; b < 4; b++)
                    if (ebe[b]) mem[wa][8*b +: 8] = ewd[8*b +: 8];
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_data", rsp_data, eld);
                @(negedge clk);
                #1;
                chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
                chk("rsp_data_hold", rsp_data, eld);
            end
        end
    endtask

    initial begin
        logic [11:0] a;
        int sz;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        dram_ack = 1'b0; dram_rdata = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_acc_err", 32'(acc_err), 32'd0);
        chk("rst_dram_req", 32'(dram_req), 32'd0);
        chk("rst_dram_we", 32'(dram_we), 32'd0);
        chk("rst_dram_addr", 32'(dram_addr), 32'd0);
        chk("rst_dram_be", 32'(dram_be), 32'd0);
        chk("rst_dram_wdata", dram_wdata, 32'd0);
        nrst = 1'b1;

        // directed cases
        mem[2] = 32'hDEADBEEF;
        xact(1'b0, 2, 1'b0, 12'h008, 32'h0, 2);
        mem[0] = 32'h80FF0000;
        xact(1'b0, 0, 1'b0, 12'h003, 32'h0, 1);
        xact(1'b0, 0, 1'b1, 12'h003, 32'h0, 3);
        xact(1'b1, 1, 1'b0, 12'h006, 32'h1234, 1);
        xact(1'b0, 1, 1'b0, 12'h006, 32'h0, 1);   // read back the half
        xact(1'b0, 2, 1'b0, 12'h005, 32'h0, 1);   // misaligned word
        xact(1'b0, 3, 1'b0, 12'h000, 32'h0, 1);   // dword on 32-bit path
        xact(1'b0, 2, 1'b0, 12'h010, 32'h0, 0);   // never acked
        // late ack after timeout is ignored
        @(negedge clk);
        dram_ack = 1'b1;
        #1;
        chk("late_ack_stall", 32'(stall), 32'd0);
        @(negedge clk);
        dram_ack = 1'b0;
        #1;
        chk("late_ack_no_rsp", 32'(rsp_valid), 32'd0);
        chk("late_ack_no_req", 32'(dram_req), 32'd0);
        xact(1'b0, 2, 1'b0, 12'h010, 32'h0, 2);   // follow-up completes

        // reset while in ACCESS
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 12'h040;
        #1;
        chk("rst_acc_accept_stall", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rst_acc_req_before", 32'(dram_req), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_acc_req", 32'(dram_req), 32'd0);
        chk("rst_acc_stall", 32'(stall), 32'd0);
        chk("rst_acc_rsp", 32'(rsp_valid), 32'd0);
        nrst = 1'b1;
        dram_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_acc_stray_ack_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_acc_stray_ack_req", 32'(dram_req), 32'd0);
        dram_ack = 1'b0;

`ifdef LSU_STORE_BUF_EN
        // posted store followed by a load
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h020;
        req_wdata = 32'hA5A5_5A5A;
        #1;
        chk("post_store_no_stall", 32'(stall), 32'd0);
        @(negedge clk);
        req_we = 1'b0; req_addr = 12'h020;
        #1;
        chk("post_load_waits", 32'(stall), 32'd1);
        chk("post_store_in_flight", 32'(dram_we), 32'd1);
        @(negedge clk);
        dram_ack = 1'b1;
        #1;
        chk("post_load_waits_ack", 32'(stall), 32'd1);
        mem[8] = 32'hA5A5_5A5A;
        @(negedge clk);
        dram_ack = 1'b0;
        #1;
        chk("post_load_accept_stall", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; dram_ack = 1'b1; dram_rdata = mem[8];
        #1;
        chk("post_load_access_we", 32'(dram_we), 32'd0);
        @(negedge clk);
        dram_ack = 1'b0;
        #1;
        chk("post_load_rsp", 32'(rsp_valid), 32'd1);
        chk("post_load_data", rsp_data, 32'hA5A5_5A5A);
`endif

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            sz = int'($urandom_range(0, 3));
            a  = 12'($urandom);
            if ($urandom_range(0, 3) != 0) a = a & ~12'((1 << sz) - 1);
            xact(1'($urandom), sz, 1'($urandom), a, $urandom,
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Parametrised load/store unit for the MEM stage of the RISC-V core. It converts the ALU address, store data and load/store configuration into a word-oriented DRAM request/acknowledge transaction with byte enables. It supports variable-latency memory and asserts a pipeline stall while a transaction is outstanding. Loads are returned sign- or zero-extended and aligned; misaligned accesses are flagged.

Parameters:
DATA_W, 32, data path width in bits (32 or 64); BE_W = DATA_W/8
ADDR_W, 12, byte address width
OFS_W, $clog2(DATA_W/8), byte-offset bits within a word (derived)
TIMEOUT, 255, maximum cycles to wait for dram_ack before an access error is raised

Ports:
clk  in  1  clock
nrst  in  1  reset
req_valid  in  1  MEM-stage access request, held until accepted
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W=64 only)
req_unsigned  in  1  zero-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-justified
stall  out  1  freeze the pipeline upstream of MEM
rsp_valid  out  1  one-cycle pulse: load data is valid
rsp_data  out  DATA_W  extended load result
misalign  out  1  one-cycle pulse on a misaligned request
acc_err  out  1  one-cycle pulse on timeout
dram_req  out  1  memory request
dram_we  out  1  write qualifier
dram_addr  out  ADDR_W-OFS_W  word address
dram_be  out  BE_W  byte enables
dram_wdata  out  DATA_W  lane-shifted store data
dram_ack  in  1  memory done; for reads, dram_rdata is valid in the same cycle
dram_rdata  in  DATA_W  memory read word

Behaviour:
- Reset: nrst is synchronous and active-low; clock is clk. On reset the FSM goes to IDLE, the timeout counter clears, and every output is driven to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req_valid=1 and aligned:
  - Register the word address, byte enables, shifted data, size, unsigned flag and offset.
  - Go to ACCESS; dram_req=1 from the next cycle.
  - stall=1 combinationally in the accept cycle and for every following cycle until the transaction completes.
- IDLE, req_valid=1 and misaligned (half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0, or dword when DATA_W=32):
  - misalign=1 for that cycle only.
  - No DRAM access, no stall, stay in IDLE.
- ACCESS:
  - dram_req, dram_we, dram_addr, dram_be and dram_wdata are held stable until dram_ack.
  - On dram_ack for a store: go to IDLE; stall is deasserted in the ack cycle.
  - On dram_ack for a load: capture the extracted and extended data, then go to RESP.
- RESP: rsp_valid=1 for one cycle, stall=0, then return to IDLE. rsp_data holds its value until the next load completes.
- Load latency: at least 3 cycles from accept (accept, ACCESS with ack, RESP).
- Byte enables: base mask of 1, 2, 4 or 8 bits, shifted left by the offset. Store data is shifted left by offset×8.
- Load extraction: rdata >> (offset×8), truncated to the size, then sign-extended by the top bit unless req_unsigned=1.
- Timeout: the counter increments in ACCESS and resets on ack.
  - When it reaches TIMEOUT: drop dram_req, acc_err=1 for one cycle, no rsp_valid, return to IDLE, stall=0.
  - A late dram_ack in IDLE is ignored.
- dram_ack in IDLE or RESP is ignored.
- Reset during ACCESS aborts the access: dram_req=0 on the next edge and no response is generated.

Optional Feature:
LSU_STORE_BUF_EN
- Defined: a one-entry posted store buffer.
  - A store accepted in IDLE with an empty buffer produces no stall; the buffer drains in the background.
  - A second store or any load while the buffer is busy stalls until it drains.
  - No store-to-load forwarding.
  - Timeout on a posted store raises acc_err and discards the store.
- Undefined: stores stall until dram_ack as described in Behaviour.

Decomposition:
- Package lsu_pkg:
  - enum mem_size_t {SZ_B, SZ_H, SZ_W, SZ_D}
  - enum lsu_state_t {IDLE, ACCESS, RESP}
  - function be_mask(size, offset)
- Sub-module lsu_align: purely combinational store-lane shift, byte-enable generation, and load extract/extend. It is reused by the store buffer.

Test Plan:
- Load word at addr 0x008, dram_rdata=0xDEADBEEF, ack after 2 cycles -> dram_addr=0x002, dram_be=4'hF; stall high for 3 cycles; rsp_valid with rsp_data=0xDEADBEEF.
- Signed byte load at addr 0x003, rdata=0x80FF0000 -> dram_be=4'h8, rsp_data=0xFFFFFF80. Same load with req_unsigned=1 -> 0x00000080.
- Store half 0x1234 at addr 0x006 -> dram_we=1, dram_be=4'hC, dram_wdata=0x12340000; stall drops in the ack cycle.
- Word load at addr 0x005 -> misalign pulse, dram_req stays 0, stall=0.
- Load with dram_ack never asserted (TIMEOUT=8) -> acc_err after 8 ACCESS cycles; FSM returns to IDLE; a following load completes normally.
- nrst=0 while in ACCESS -> next cycle dram_req=0, stall=0, rsp_valid=0. With LSU_STORE_BUF_EN: store followed by load -> store shows no stall; the load stalls until the store's ack.
